// File: rtl/pcs_lane_pkg.sv
// Shared lane-ID constants, FSM encoding and packed-bus field helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pcs_lane_pkg;

    localparam int N_LANES   = 4;
    localparam int NB_ID     = $clog2(N_LANES);
    localparam int NB_ID_BUS = NB_ID * N_LANES;

    localparam logic [2:0] ST_IDLE_ENC    = 3'd0;
    localparam logic [2:0] ST_COLLECT_ENC = 3'd1;
    localparam logic [2:0] ST_BUILD_ENC   = 3'd2;
    localparam logic [2:0] ST_CHECK_ENC   = 3'd3;
    localparam logic [2:0] ST_LOCKED_ENC  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = ST_IDLE_ENC,
        ST_COLLECT = ST_COLLECT_ENC,
        ST_BUILD   = ST_BUILD_ENC,
        ST_CHECK   = ST_CHECK_ENC,
        ST_LOCKED  = ST_LOCKED_ENC
    } state_e;

    typedef logic [NB_ID-1:0]     lane_id_t;
    typedef logic [NB_ID_BUS-1:0] id_bus_t;

    // Field idx of an MSB-first bus: field 0 occupies the top NB_ID bits.
    function automatic lane_id_t get_field(input id_bus_t bus, input int idx);
        lane_id_t f;
        f = '0;
        for (int k = 0; k < N_LANES; k++) begin
            if (k == idx) f = bus[NB_ID_BUS - NB_ID*k - 1 -: NB_ID];
        end
        return f;
    endfunction

    function automatic id_bus_t set_field(input id_bus_t bus, input int idx, input lane_id_t val);
        id_bus_t r;
        r = bus;
        for (int k = 0; k < N_LANES; k++) begin
            if (k == idx) r[NB_ID_BUS - NB_ID*k - 1 -: NB_ID] = val;
        end
        return r;
    endfunction

    // Only meaningful when N_LANES is not a power of two; otherwise every code is legal.
    function automatic logic id_in_range(input lane_id_t id);
        return int'(id) < N_LANES;
    endfunction

endpackage

// File: rtl/lane_id_mapper_if.sv
// AM status inputs and lane-map outputs of the lane ID mapper.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are levels or single-cycle strobes.
interface lane_id_mapper_if;
    import pcs_lane_pkg::*;

    logic [N_LANES-1:0] i_am_lock;
    logic [N_LANES-1:0] i_am_valid;
    id_bus_t            i_logical_ids;
    id_bus_t            o_lane_ids;
    logic               o_reorder_done;
    logic               o_map_valid;
    logic               o_id_error;

    modport master (
        output i_am_lock, i_am_valid, i_logical_ids,
        input  o_lane_ids, o_reorder_done, o_map_valid, o_id_error
    );

    modport slave (
        input  i_am_lock, i_am_valid, i_logical_ids,
        output o_lane_ids, o_reorder_done, o_map_valid, o_id_error
    );
endinterface

// File: rtl/lane_id_capture.sv
// Per-physical-lane first-AM capture of the logical ID, plus compare against captured IDs.
// Latency: capture registers on the strobe edge; mask_full/mismatch are combinational.
// Backpressure: none; repeated AMs on a captured lane are dropped, i_enable low holds state.
module lane_id_capture
    import pcs_lane_pkg::*;
(
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic               i_clear,
    input  logic               i_capture_en,
    input  logic               i_compare_en,
    input  logic [N_LANES-1:0] i_am_valid,
    input  id_bus_t            i_logical_ids,
    output logic               o_mask_full,
    output id_bus_t            o_id_regs,
    output logic               o_mismatch
);

    logic [N_LANES-1:0] mask_d, mask_q;
    id_bus_t            id_regs_d, id_regs_q;

    // Mask is complete this cycle if every lane is either already held or arriving now.
    assign o_mask_full = &(mask_q | (i_am_valid & {N_LANES{i_capture_en}}));
    assign o_id_regs   = id_regs_q;

    // Latch the first AM per lane; flag any AM that disagrees with the held ID.
    always_comb begin
        mask_d     = mask_q;
        id_regs_d  = id_regs_q;
        o_mismatch = 1'b0;
        for (int i = 0; i < N_LANES; i++) begin
            if (i_capture_en && i_am_valid[i] && !mask_q[i]) begin
                mask_d[i] = 1'b1;
                id_regs_d = set_field(id_regs_d, i, get_field(i_logical_ids, i));
            end
            if (i_compare_en && i_am_valid[i] &&
                (get_field(i_logical_ids, i) != get_field(id_regs_q, i))) begin
                o_mismatch = 1'b1;
            end
        end
        if (i_clear) mask_d = '0;
    end

    // Capture state registers.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            mask_q    <= '0;
            id_regs_q <= '0;
        end else if (i_enable) begin
            mask_q    <= mask_d;
            id_regs_q <= id_regs_d;
        end
    end

endmodule

// File: rtl/lane_id_mapper.sv
// Validates per-lane AM IDs as a permutation and publishes the logical->physical map.
// Latency: map and done pulse appear N_LANES+2 edges after the cycle the last ID arrives.
// Backpressure: none; i_enable low freezes every register, lock loss tears the map down.
module lane_id_mapper
    import pcs_lane_pkg::*;
(
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_enable,
    lane_id_mapper_if.slave  bus
);

    state_e             state_d, state_q;
    lane_id_t           cnt_d, cnt_q;
    logic [N_LANES-1:0] seen_d, seen_q;
    logic               err_d, err_q;
    id_bus_t            inv_d, inv_q;
    id_bus_t            lane_ids_d, lane_ids_q;
    logic               done_d, done_q;
    logic               map_valid_d, map_valid_q;
    logic               id_error_d, id_error_q;

    logic     all_lock;
    logic     mask_clear;
    logic     capture_en;
    logic     compare_en;
    logic     mask_full;
    logic     mismatch;
    id_bus_t  id_regs;
    lane_id_t build_id;

    assign all_lock   = &bus.i_am_lock;
    assign capture_en = (state_q == ST_COLLECT);
    assign compare_en = (state_q == ST_LOCKED);
    assign build_id   = get_field(id_regs, int'(cnt_q));

    lane_id_capture u_capture (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_enable      (i_enable),
        .i_clear       (mask_clear),
        .i_capture_en  (capture_en),
        .i_compare_en  (compare_en),
        .i_am_valid    (bus.i_am_valid),
        .i_logical_ids (bus.i_logical_ids),
        .o_mask_full   (mask_full),
        .o_id_regs     (id_regs),
        .o_mismatch    (mismatch)
    );

    // Sequencing: collect IDs, walk one physical lane per cycle building the inverse map, then commit.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        seen_d      = seen_q;
        err_d       = err_q;
        inv_d       = inv_q;
        lane_ids_d  = lane_ids_q;
        map_valid_d = map_valid_q;
        done_d      = 1'b0;
        id_error_d  = 1'b0;
        mask_clear  = 1'b0;

        if (state_q != ST_IDLE && !all_lock) begin
            // Lock loss outranks every other event; the last published map stays on the bus.
            state_d     = ST_IDLE;
            map_valid_d = 1'b0;
            mask_clear  = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (all_lock) begin
                        state_d    = ST_COLLECT;
                        mask_clear = 1'b1;
                    end
                end
                ST_COLLECT: begin
                    if (mask_full) begin
                        state_d = ST_BUILD;
                        cnt_d   = '0;
                        seen_d  = '0;
                        err_d   = 1'b0;
                    end
                end
                ST_BUILD: begin
                    if (!id_in_range(build_id) || seen_q[build_id]) begin
                        err_d = 1'b1;
                    end else begin
                        inv_d            = set_field(inv_q, int'(build_id), cnt_q);
                        seen_d[build_id] = 1'b1;
                    end
                    if (cnt_q == lane_id_t'(N_LANES - 1)) begin
                        state_d = ST_CHECK;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (err_q) begin
                        id_error_d = 1'b1;
                        mask_clear = 1'b1;
                        state_d    = ST_COLLECT;
                    end else begin
                        lane_ids_d  = inv_q;
                        done_d      = 1'b1;
                        map_valid_d = 1'b1;
                        state_d     = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (mismatch) begin
                        id_error_d  = 1'b1;
                        map_valid_d = 1'b0;
                        mask_clear  = 1'b1;
                        state_d     = ST_COLLECT;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers; reset wins over enable.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            seen_q      <= '0;
            err_q       <= 1'b0;
            inv_q       <= '0;
            lane_ids_q  <= '0;
            done_q      <= 1'b0;
            map_valid_q <= 1'b0;
            id_error_q  <= 1'b0;
        end else if (i_enable) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            seen_q      <= seen_d;
            err_q       <= err_d;
            inv_q       <= inv_d;
            lane_ids_q  <= lane_ids_d;
            done_q      <= done_d;
            map_valid_q <= map_valid_d;
            id_error_q  <= id_error_d;
        end
    end

    assign bus.o_lane_ids     = lane_ids_q;
    assign bus.o_reorder_done = done_q;
    assign bus.o_map_valid    = map_valid_q;
    assign bus.o_id_error     = id_error_q;

endmodule

// File: doc/lane_id_mapper.md
Name: lane_id_mapper

Overview:
- Sits directly upstream of the lane reorder/serializer stage (lane_swap_v2).
- Collects the logical lane ID decoded from each physical lane's alignment marker (AM).
- Validates that the IDs form a permutation of 0..N_LANES-1, then builds the inverse map (logical lane -> physical lane).
- Presents the map as the selector bus plus a one-cycle reorder_done strobe, and tears the map down on lock loss or ID change.

Parameters:
- NB_ID, $clog2(N_LANES), width of one lane ID.
- NB_ID_BUS, NB_ID*N_LANES, width of the packed ID buses.

Ports:
- i_clock  in  1  single clock, all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  clock enable; when low, all registers hold.
- i_am_lock  in  N_LANES  per-physical-lane AM lock; bit i = phy lane i.
- i_am_valid  in  N_LANES  per-lane strobe: AM decoded this cycle; bit i = phy lane i.
- i_logical_ids  in  NB_ID_BUS  decoded IDs, {phy_0, ..., phy_N-1}, MSB first; field i is valid when i_am_valid[i]=1.
- o_lane_ids  out  NB_ID_BUS  map {sel_logical_0, ..., sel_logical_N-1}, MSB first; sel = physical lane index.
- o_reorder_done  out  1  one-cycle pulse when a new map becomes valid.
- o_map_valid  out  1  level; o_lane_ids is usable.
- o_id_error  out  1  one-cycle pulse on duplicate, out-of-range or changed ID.

Behaviour:
- Reset values: o_lane_ids=0, o_reorder_done=0, o_map_valid=0, o_id_error=0. Internally: state=IDLE, capture mask=0, counter=0, seen vector=0.
- All transitions and updates happen only on cycles with i_enable=1. i_reset takes priority over i_enable.
- FSM states: IDLE, COLLECT, BUILD, CHECK, LOCKED.
- IDLE: when i_am_lock is all ones -> COLLECT; clear the mask.
- COLLECT:
  - For each lane with i_am_valid[i]=1 and mask[i]=0, latch that lane's ID into id_reg[i] and set mask[i].
  - A repeated AM on an already-captured lane is ignored.
  - When the mask becomes all ones (edge E0) -> BUILD, counter=0, seen=0, err=0.
- BUILD: one physical lane per cycle, counter p = 0..N_LANES-1.
  - If id_reg[p] >= N_LANES or seen[id_reg[p]]=1, set err.
  - Otherwise write inv[id_reg[p]] = p and set seen.
  - After p = N_LANES-1 (edge E0+N_LANES) -> CHECK.
- CHECK (one cycle):
  - No err: at edge E0+N_LANES+1, load o_lane_ids from inv, pulse o_reorder_done, set o_map_valid, go to LOCKED.
  - err: pulse o_id_error, clear the mask, go to COLLECT.
- LOCKED:
  - o_lane_ids holds.
  - An AM whose ID differs from id_reg for that lane: pulse o_id_error, clear o_map_valid, clear the mask, go to COLLECT.
  - A matching AM has no effect.
- Lock loss: any i_am_lock bit low in COLLECT, BUILD, CHECK or LOCKED -> IDLE next edge, o_map_valid=0, mask cleared. o_lane_ids retains its last value. Lock loss has priority over ID mismatch and over CHECK completion.
- Latency: done pulse comes N_LANES+2 edges after the first cycle with the mask complete.
- Widths:
  - ID range check is done at NB_ID width; for non-power-of-2 N_LANES the out-of-range values are illegal.
  - Counter is NB_ID bits and must not wrap past N_LANES-1.
- o_reorder_done and o_id_error are never high in the same cycle.

Decomposition:
- Shared package pcs_lane_pkg holds:
  - N_LANES and NB_ID constants;
  - FSM state encoding (3-bit localparams);
  - field-slicing helpers for the MSB-first packed buses (phy field i = [NB_ID_BUS-NB_ID*i-1 -: NB_ID]).
- One natural sub-module: lane_id_capture. It implements the per-lane mask/id_reg capture and the LOCKED mismatch compare, instantiated once with vector ports.
- BUILD/CHECK logic and the output registers stay in the top.

Test Plan (N_LANES=4, NB_ID=2 unless noted):
- Identity map: lock all, AMs with IDs phy0..3 = 0,1,2,3 -> done pulse exactly 6 edges after mask complete, o_lane_ids = {0,1,2,3}, o_map_valid=1.
- Permuted map: phy IDs = 2,0,3,1, AMs arriving on different cycles -> o_lane_ids = {1,3,0,2}, single done pulse, no error.
- Duplicate ID: phy IDs = 1,1,2,3 -> o_id_error pulse after BUILD, no done, o_map_valid=0, FSM back in COLLECT; then valid AMs 3,2,1,0 -> o_lane_ids = {3,2,1,0}.
- Lock loss mid-BUILD: drop i_am_lock[2] during BUILD -> IDLE next edge, no done, no error. Re-lock and re-collect -> normal done.
- LOCKED mismatch: after map {0,1,2,3}, phy1 reports ID 3 -> o_id_error pulse, o_map_valid=0, then re-collect.
- Enable gating and reset: toggle i_enable at 50% during collect/build -> done is delayed by exactly the number of disabled cycles. i_reset asserted in LOCKED -> all outputs 0 next edge.
